// File: rtl/fe_ibuf.sv
// Front-end instruction buffer: DEPTH-entry circular queue between I-cache fill and decode.
// Define FE_IBUF_BYPASS_EN to present fill lanes to decode in the same cycle when the queue is empty.
module fe_ibuf #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ENQ_W   = 2,
  parameter int unsigned DEQ_W   = 2,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned SEQ_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fill_valid,
  input  logic [$clog2(ENQ_W+1)-1:0]   fill_cnt,
  input  logic [ENQ_W*PC_W-1:0]        fill_pc,
  input  logic [ENQ_W*INSTR_W-1:0]     fill_instr,
  output logic                         fill_ready,
  input  logic                         flush,
  input  logic                         decode_ready_de0,
  output logic [DEQ_W-1:0]             valid_fe1,
  output logic [DEQ_W*PC_W-1:0]        pc_fe1,
  output logic [DEQ_W*INSTR_W-1:0]     instr_fe1,
  output logic [DEQ_W*SEQ_W-1:0]       seq_fe1,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(ENQ_W+1);
  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [SEQ_W-1:0]   r_seq   [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [OCC_W-1:0]   r_occ;
  logic [SEQ_W-1:0]   r_next_seq;

  logic               w_enq;
  logic [OCC_W-1:0]   w_enq_cnt;
  logic [OCC_W-1:0]   w_qcnt;
  logic [OCC_W-1:0]   w_skip;
  logic [OCC_W-1:0]   w_deq_cnt;
  logic [OCC_W-1:0]   w_wr_cnt;

  assign fill_ready = (OCC_W'(DEPTH) - r_occ) >= OCC_W'(ENQ_W);
  assign w_enq      = fill_valid & fill_ready & ~flush;
  assign w_enq_cnt  = w_enq ? OCC_W'(fill_cnt) : '0;
  assign occupancy  = r_occ;

  always_comb begin
    valid_fe1 = '0;
    pc_fe1    = '0;
    instr_fe1 = '0;
    seq_fe1   = '0;
    w_qcnt    = '0;
    w_skip    = '0;
    for (int unsigned i = 0; i < DEQ_W; i++) begin
      if (r_occ > OCC_W'(i)) begin
        valid_fe1[i]                   = 1'b1;
        pc_fe1[i*PC_W +: PC_W]         = r_pc[r_head + PTR_W'(i)];
        instr_fe1[i*INSTR_W +: INSTR_W] = r_instr[r_head + PTR_W'(i)];
        seq_fe1[i*SEQ_W +: SEQ_W]      = r_seq[r_head + PTR_W'(i)];
        w_qcnt                         = w_qcnt + OCC_W'(1);
      end
    end
`ifdef FE_IBUF_BYPASS_EN
    // Empty queue: lanes come straight from the fill beat; consumed lanes are never written.
    if ((r_occ == '0) && w_enq) begin
      for (int unsigned i = 0; i < DEQ_W; i++) begin
        if ((i < ENQ_W) && (OCC_W'(i) < w_enq_cnt)) begin
          valid_fe1[i]                    = 1'b1;
          pc_fe1[i*PC_W +: PC_W]          = fill_pc[i*PC_W +: PC_W];
          instr_fe1[i*INSTR_W +: INSTR_W] = fill_instr[i*INSTR_W +: INSTR_W];
          seq_fe1[i*SEQ_W +: SEQ_W]       = r_next_seq + SEQ_W'(i);
          if (decode_ready_de0) w_skip = w_skip + OCC_W'(1);
        end
      end
    end
`endif
  end

  assign w_deq_cnt = (decode_ready_de0 & ~flush) ? w_qcnt : '0;
  assign w_wr_cnt  = w_enq_cnt - w_skip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
      r_next_seq <= '0;
    end else if (flush) begin
      r_head <= r_tail;
      r_occ  <= '0;
    end else begin
      r_tail     <= r_tail + PTR_W'(w_wr_cnt);
      r_head     <= r_head + PTR_W'(w_deq_cnt);
      r_occ      <= r_occ + w_wr_cnt - w_deq_cnt;
      r_next_seq <= r_next_seq + SEQ_W'(w_enq_cnt);
    end
  end

  // Storage needs no reset; lanes below w_skip were consumed by bypass and keep their seq numbering.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENQ_W; i++) begin
      if ((OCC_W'(i) >= w_skip) && (OCC_W'(i) < w_enq_cnt)) begin
        r_pc[r_tail + PTR_W'(i) - PTR_W'(w_skip)]    <= fill_pc[i*PC_W +: PC_W];
        r_instr[r_tail + PTR_W'(i) - PTR_W'(w_skip)] <= fill_instr[i*INSTR_W +: INSTR_W];
        r_seq[r_tail + PTR_W'(i) - PTR_W'(w_skip)]   <= r_next_seq + SEQ_W'(i);
      end
    end
  end

  a_fill_cnt_legal: assert property (@(posedge clk) disable iff (!reset)
    fill_valid |-> (fill_cnt <= CNT_W'(ENQ_W)));

endmodule

// File: tb/tb_fe_ibuf.sv
// Directed self-checking bench for fe_ibuf in its default (no bypass) build, DEPTH=8, ENQ_W=DEQ_W=2.
module tb_fe_ibuf;

  logic        clk;
  logic        reset;
  logic        fill_valid;
  logic [1:0]  fill_cnt;
  logic [63:0] fill_pc;
  logic [63:0] fill_instr;
  logic        fill_ready;
  logic        flush;
  logic        decode_ready_de0;
  logic [1:0]  valid_fe1;
  logic [63:0] pc_fe1;
  logic [63:0] instr_fe1;
  logic [15:0] seq_fe1;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  fe_ibuf #(.DEPTH(8), .ENQ_W(2), .DEQ_W(2), .PC_W(32), .INSTR_W(32), .SEQ_W(8)) dut (
    .clk(clk), .reset(reset), .fill_valid(fill_valid), .fill_cnt(fill_cnt),
    .fill_pc(fill_pc), .fill_instr(fill_instr), .fill_ready(fill_ready), .flush(flush),
    .decode_ready_de0(decode_ready_de0), .valid_fe1(valid_fe1), .pc_fe1(pc_fe1),
    .instr_fe1(instr_fe1), .seq_fe1(seq_fe1), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_fill(input logic [1:0] cnt, input logic [31:0] pc0);
    fill_valid = 1'b1;
    fill_cnt   = cnt;
    fill_pc    = {pc0 + 32'd4, pc0};
    fill_instr = {~(pc0 + 32'd4), ~pc0};
  endtask

  task automatic idle();
    fill_valid = 1'b0;
    fill_cnt   = 2'd0;
    fill_pc    = '0;
    fill_instr = '0;
  endtask

  task automatic do_reset();
    idle();
    flush = 1'b0;
    decode_ready_de0 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_fe1 !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", valid_fe1); end
    checks++; if (pc_fe1 !== 64'd0 || instr_fe1 !== 64'd0 || seq_fe1 !== 16'd0) begin errors++; $display("FAIL reset_data got pc %h instr %h seq %h want 0", pc_fe1, instr_fe1, seq_fe1); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (fill_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", fill_ready); end
    decode_ready_de0 = 1'b1;
    tick();
    decode_ready_de0 = 1'b0;
    checks++; if (occupancy !== 4'd0 || valid_fe1 !== 2'b00) begin errors++; $display("FAIL empty_decode got occ %0d valid %b want 0 00", occupancy, valid_fe1); end
  endtask

  task automatic test_fill_basic();
    do_reset();
    set_fill(2'd2, 32'h100);
    checks++; if (valid_fe1 !== 2'b00) begin errors++; $display("FAIL fill_latency got %b want 00", valid_fe1); end
    tick();
    idle();
    checks++; if (valid_fe1 !== 2'b11) begin errors++; $display("FAIL fill_valid got %b want 11", valid_fe1); end
    checks++; if (pc_fe1 !== {32'h104, 32'h100}) begin errors++; $display("FAIL fill_pc got %h want 0000010400000100", pc_fe1); end
    checks++; if (instr_fe1 !== {~32'h104, ~32'h100}) begin errors++; $display("FAIL fill_instr got %h", instr_fe1); end
    checks++; if (seq_fe1 !== {8'd1, 8'd0}) begin errors++; $display("FAIL fill_seq got %h want 0100", seq_fe1); end
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL fill_occ got %0d want 2", occupancy); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_fill(2'd2, 32'h1000 + 32'(8 * k));
      tick();
      if (k == 2) begin
        checks++; if (occupancy !== 4'd6 || fill_ready !== 1'b1) begin errors++; $display("FAIL occ6_ready got occ %0d ready %b want 6 1", occupancy, fill_ready); end
      end
    end
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ got %0d want 8", occupancy); end
    checks++; if (fill_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", fill_ready); end
    set_fill(2'd2, 32'h2000);
    tick();
    checks++; if (occupancy !== 4'd8 || pc_fe1[31:0] !== 32'h1000) begin errors++; $display("FAIL full_reject got occ %0d pc0 %h want 8 1000", occupancy, pc_fe1[31:0]); end
    set_fill(2'd2, 32'h3000);
    decode_ready_de0 = 1'b1;
    tick();
    idle();
    decode_ready_de0 = 1'b0;
    checks++; if (occupancy !== 4'd6) begin errors++; $display("FAIL full_drain_occ got %0d want 6", occupancy); end
    checks++; if (pc_fe1 !== {32'h100C, 32'h1008} || seq_fe1 !== {8'd3, 8'd2}) begin errors++; $display("FAIL full_drain_head got pc %h seq %h want 0000100c00001008 0302", pc_fe1, seq_fe1); end
    checks++; if (fill_ready !== 1'b1) begin errors++; $display("FAIL full_drain_ready got %b want 1", fill_ready); end
  endtask

  task automatic test_back_to_back();
    int unsigned nf;
    int unsigned nd;
    do_reset();
    nf = 0;
    set_fill(2'd2, 32'h4000 + 32'(4 * nf));
    tick();
    nf += 2;
    decode_ready_de0 = 1'b1;
    repeat (124) begin
      set_fill(2'd2, 32'h4000 + 32'(4 * nf));
      tick();
      nf += 2;
    end
    nd = nf - 2;
    for (int c = 0; c < 20; c++) begin
      checks++; if (occupancy !== 4'd2 || valid_fe1 !== 2'b11) begin errors++; $display("FAIL steady_occ c%0d got occ %0d valid %b want 2 11", c, occupancy, valid_fe1); end
      checks++; if (pc_fe1 !== {32'h4000 + 32'(4 * (nd + 1)), 32'h4000 + 32'(4 * nd)}) begin errors++; $display("FAIL steady_pc c%0d got %h want %h_%h", c, pc_fe1, 32'h4000 + 32'(4 * (nd + 1)), 32'h4000 + 32'(4 * nd)); end
      checks++; if (seq_fe1 !== {8'(nd + 1), 8'(nd)}) begin errors++; $display("FAIL steady_seq c%0d got %h want %h%h", c, seq_fe1, 8'(nd + 1), 8'(nd)); end
      checks++; if (instr_fe1[31:0] !== ~(32'h4000 + 32'(4 * nd))) begin errors++; $display("FAIL steady_instr c%0d got %h", c, instr_fe1[31:0]); end
      set_fill(2'd2, 32'h4000 + 32'(4 * nf));
      tick();
      nf += 2;
      nd += 2;
    end
    idle();
    decode_ready_de0 = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    set_fill(2'd2, 32'h700); tick();
    set_fill(2'd2, 32'h708); tick();
    set_fill(2'd1, 32'h710); tick();
    set_fill(2'd0, 32'h7F0); tick();
    checks++; if (occupancy !== 4'd5 || fill_ready !== 1'b1) begin errors++; $display("FAIL cnt0_noop got occ %0d ready %b want 5 1", occupancy, fill_ready); end
    set_fill(2'd2, 32'h800);
    decode_ready_de0 = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    decode_ready_de0 = 1'b0;
    idle();
    checks++; if (occupancy !== 4'd0 || valid_fe1 !== 2'b00) begin errors++; $display("FAIL flush_empty got occ %0d valid %b want 0 00", occupancy, valid_fe1); end
    set_fill(2'd1, 32'h900);
    tick();
    idle();
    checks++; if (valid_fe1 !== 2'b01 || occupancy !== 4'd1) begin errors++; $display("FAIL post_flush_valid got %b occ %0d want 01 1", valid_fe1, occupancy); end
    checks++; if (pc_fe1 !== {32'h0, 32'h900}) begin errors++; $display("FAIL post_flush_pc got %h want 0000000000000900", pc_fe1); end
    checks++; if (seq_fe1 !== {8'd0, 8'd5}) begin errors++; $display("FAIL post_flush_seq got %h want 0005", seq_fe1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_fill(2'd2, 32'h500); tick();
    set_fill(2'd1, 32'h600); tick();
    idle();
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL mid_pre_occ got %0d want 3", occupancy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (valid_fe1 !== 2'b00 || pc_fe1 !== 64'd0 || seq_fe1 !== 16'd0) begin errors++; $display("FAIL mid_reset_out got valid %b pc %h seq %h want 0", valid_fe1, pc_fe1, seq_fe1); end
    checks++; if (occupancy !== 4'd0 || fill_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_occ got occ %0d ready %b want 0 1", occupancy, fill_ready); end
    @(negedge clk);
    reset = 1'b1;
    set_fill(2'd1, 32'h200);
    tick();
    idle();
    checks++; if (valid_fe1 !== 2'b01 || pc_fe1[31:0] !== 32'h200 || seq_fe1[7:0] !== 8'd0) begin errors++; $display("FAIL mid_refill got valid %b pc0 %h seq0 %h want 01 200 00", valid_fe1, pc_fe1[31:0], seq_fe1[7:0]); end
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    decode_ready_de0 = 1'b0;
    idle();
    test_reset();
    test_fill_basic();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
